hawk_axi_rd_arb: RTL and testbench

- Shares the single HAWK AXI4 read master (AR/R channels) between two requesters.
  - Requester 0: page-manager (ATT / TOL lookups).
  - Requester 1: compression-manager (TOL / zspage metadata reads).
- Round-robin AR arbitration; registered AR issue.
- Up to OUTSTD in-order outstanding reads, owner tracked in a tag FIFO.
- R beats routed back to the owning requester.

---
 rtl/hawk_axi_rd_arb.sv | 177 +++++++++++++++++
 tb/tb_hawk_axi_rd_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_axi_rd_arb.sv
// Two-requester round-robin arbiter onto one AXI4 read master (AR/R).
// Owners of in-flight bursts are kept in order in a small tag FIFO for R routing.
module hawk_axi_rd_arb #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned OUTSTD = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rq0_arvalid,
  output logic              rq0_arready,
  input  logic [ADDR_W-1:0] rq0_araddr,
  input  logic [7:0]        rq0_arlen,
  output logic              rq0_rvalid,
  input  logic              rq0_rready,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic [1:0]        rq0_rresp,
  output logic              rq0_rlast,
  input  logic              rq1_arvalid,
  output logic              rq1_arready,
  input  logic [ADDR_W-1:0] rq1_araddr,
  input  logic [7:0]        rq1_arlen,
  output logic              rq1_rvalid,
  input  logic              rq1_rready,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic [1:0]        rq1_rresp,
  output logic              rq1_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [ID_W-1:0]   m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  output logic              busy_o,
  output logic              err_id_o,
  output logic              err_unexp_o
);

  localparam int unsigned PW = $clog2(OUTSTD);
  localparam logic [PW:0] Full = (PW+1)'(OUTSTD);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e            state_q;
  logic              last_grant_q, owner_q, m_arvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;

  logic              tag_q [OUTSTD];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;
  logic              err_id_q, err_unexp_q;

  logic grant_vld, grant_id, push, pop, empty, head;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == StIdle && cnt_q < Full) begin
      if (rq0_arvalid && rq1_arvalid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (rq0_arvalid) begin
        grant_vld = 1'b1;
      end else if (rq1_arvalid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign rq0_arready = grant_vld & ~grant_id;
  assign rq1_arready = grant_vld & grant_id;

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      m_arvalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            owner_q      <= grant_id;
            addr_q       <= grant_id ? rq1_araddr : rq0_araddr;
            len_q        <= grant_id ? rq1_arlen : rq0_arlen;
            last_grant_q <= grant_id;
            m_arvalid_q  <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arid    = {{(ID_W-1){1'b0}}, owner_q};

  assign empty = (cnt_q == '0);
  assign head  = tag_q[rd_ptr_q];
  assign push  = m_arvalid_q & m_arready;
  assign pop   = m_rvalid & m_rready & m_rlast & ~empty;

  always_ff @(posedge clk_i) begin
    if (push) tag_q[wr_ptr_q] <= owner_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  // With nothing outstanding, stray beats are drained rather than stalling the bus.
  always_comb begin
    rq0_rvalid = 1'b0;
    rq1_rvalid = 1'b0;
    m_rready   = 1'b0;
    if (empty) begin
      m_rready = m_rvalid;
    end else if (head) begin
      rq1_rvalid = m_rvalid;
      m_rready   = rq1_rready;
    end else begin
      rq0_rvalid = m_rvalid;
      m_rready   = rq0_rready;
    end
  end

  assign rq0_rdata = m_rdata;
  assign rq0_rresp = m_rresp;
  assign rq0_rlast = m_rlast;
  assign rq1_rdata = m_rdata;
  assign rq1_rresp = m_rresp;
  assign rq1_rlast = m_rlast;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_id_q    <= 1'b0;
      err_unexp_q <= 1'b0;
    end else if (m_rvalid) begin
      if (empty) err_unexp_q <= 1'b1;
      else if (m_rid != {{(ID_W-1){1'b0}}, head}) err_id_q <= 1'b1;
    end
  end

  assign err_id_o    = err_id_q;
  assign err_unexp_o = err_unexp_q;
  assign busy_o      = (state_q != StIdle) | ~empty;

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// Randomized bench for hawk_axi_rd_arb against a queue-based model of the
// arbitration, in-order ownership and error-flag rules.
module tb_hawk_axi_rd_arb;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned OUTSTD = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_ni;
  logic              rq0_arvalid, rq0_arready, rq0_rvalid, rq0_rready, rq0_rlast;
  logic [ADDR_W-1:0] rq0_araddr;
  logic [7:0]        rq0_arlen;
  logic [DATA_W-1:0] rq0_rdata;
  logic [1:0]        rq0_rresp;
  logic              rq1_arvalid, rq1_arready, rq1_rvalid, rq1_rready, rq1_rlast;
  logic [ADDR_W-1:0] rq1_araddr;
  logic [7:0]        rq1_arlen;
  logic [DATA_W-1:0] rq1_rdata;
  logic [1:0]        rq1_rresp;
  logic              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [ID_W-1:0]   m_arid, m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              busy_o, err_id_o, err_unexp_o;

  hawk_axi_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .OUTSTD(OUTSTD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rq0_arvalid(rq0_arvalid), .rq0_arready(rq0_arready), .rq0_araddr(rq0_araddr),
    .rq0_arlen(rq0_arlen), .rq0_rvalid(rq0_rvalid), .rq0_rready(rq0_rready),
    .rq0_rdata(rq0_rdata), .rq0_rresp(rq0_rresp), .rq0_rlast(rq0_rlast),
    .rq1_arvalid(rq1_arvalid), .rq1_arready(rq1_arready), .rq1_araddr(rq1_araddr),
    .rq1_arlen(rq1_arlen), .rq1_rvalid(rq1_rvalid), .rq1_rready(rq1_rready),
    .rq1_rdata(rq1_rdata), .rq1_rresp(rq1_rresp), .rq1_rlast(rq1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .busy_o(busy_o), .err_id_o(err_id_o), .err_unexp_o(err_unexp_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one pending AR slot, an owner queue, sticky flags.
  bit         pend, pend_owner, last_g, mdl_err_id, mdl_err_unexp;
  logic [63:0] pend_addr;
  logic [7:0] pend_len;
  bit         owners[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend = 0; pend_owner = 0; last_g = 1; mdl_err_id = 0; mdl_err_unexp = 0;
    pend_addr = '0; pend_len = '0;
    owners.delete();
  endtask

  task automatic idle_inputs();
    rq0_arvalid = 0; rq0_araddr = '0; rq0_arlen = '0; rq0_rready = 0;
    rq1_arvalid = 0; rq1_araddr = '0; rq1_arlen = '0; rq1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
  endtask

  // Called at posedge+1 with inputs driven; checks, advances the model, returns at next posedge+1.
  task automatic step();
    bit g_v, g_id, h, e_rr;
    #3;
    g_v = 0; g_id = 0;
    if (!pend && owners.size() < OUTSTD) begin
      if (rq0_arvalid && rq1_arvalid) begin g_v = 1; g_id = !last_g; end
      else if (rq0_arvalid) g_v = 1;
      else if (rq1_arvalid) begin g_v = 1; g_id = 1; end
    end
    check_eq("arready0", rq0_arready, g_v && !g_id);
    check_eq("arready1", rq1_arready, g_v && g_id);
    check_eq("arvalid", m_arvalid, pend);
    if (pend) begin
      check_eq("araddr", m_araddr, pend_addr);
      check_eq("arlen", m_arlen, pend_len);
      check_eq("arid", m_arid, pend_owner);
    end
    check_eq("busy", busy_o, pend || owners.size() != 0);
    check_eq("err_id", err_id_o, mdl_err_id);
    check_eq("err_unexp", err_unexp_o, mdl_err_unexp);
    if (owners.size() == 0) begin
      e_rr = m_rvalid;
      check_eq("rvalid0_empty", rq0_rvalid, 0);
      check_eq("rvalid1_empty", rq1_rvalid, 0);
    end else begin
      h = owners[0];
      e_rr = h ? rq1_rready : rq0_rready;
      check_eq("rvalid0", rq0_rvalid, m_rvalid && !h);
      check_eq("rvalid1", rq1_rvalid, m_rvalid && h);
    end
    check_eq("rready", m_rready, e_rr);
    check_eq("rdata0", rq0_rdata[63:0], m_rdata[63:0]);
    check_eq("rdata1", rq1_rdata[511:448], m_rdata[511:448]);
    check_eq("rresp0", rq0_rresp, m_rresp);
    check_eq("rlast1", rq1_rlast, m_rlast);
    if (m_rvalid) begin
      if (owners.size() == 0) mdl_err_unexp = 1;
      else if (m_rid != ID_W'(owners[0])) mdl_err_id = 1;
    end
    if (m_rvalid && e_rr && m_rlast && owners.size() != 0) void'(owners.pop_front());
    if (pend && m_arready) begin
      owners.push_back(pend_owner);
      pend = 0;
    end else if (g_v) begin
      pend = 1; pend_owner = g_id; last_g = g_id;
      pend_addr = g_id ? rq1_araddr : rq0_araddr;
      pend_len  = g_id ? rq1_arlen : rq0_arlen;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic mid_reset();
    rst_ni = 0;
    idle_inputs();
    #1;
    check_eq("rst_arvalid", m_arvalid, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_err_id", err_id_o, 0);
    check_eq("rst_err_unexp", err_unexp_o, 0);
    check_eq("rst_rready", m_rready, 0);
    model_reset();
    #2 rst_ni = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic rand_inputs();
    rq0_arvalid = $urandom_range(0, 1) == 1;
    rq1_arvalid = $urandom_range(0, 1) == 1;
    rq0_araddr  = {$urandom, $urandom};
    rq1_araddr  = {$urandom, $urandom};
    rq0_arlen   = 8'($urandom_range(0, 255));
    rq1_arlen   = 8'($urandom_range(0, 255));
    rq0_rready  = $urandom_range(0, 3) != 0;
    rq1_rready  = $urandom_range(0, 3) != 0;
    m_arready   = $urandom_range(0, 2) != 0;
    m_rvalid    = $urandom_range(0, 1) == 1;
    m_rlast     = $urandom_range(0, 2) == 0;
    m_rresp     = 2'($urandom_range(0, 3));
    for (int i = 0; i < DATA_W / 32; i++) m_rdata[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 9) == 0) m_rid = ID_W'($urandom_range(0, 15));
    else m_rid = (owners.size() != 0) ? ID_W'(owners[0]) : '0;
  endtask

  initial begin
    rst_ni = 0;
    idle_inputs();
    model_reset();
    #12 rst_ni = 1;
    @(posedge clk_i); #1;

    // Single requester-0 read, one beat.
    rq0_arvalid = 1; rq0_araddr = 64'h1000_0040; rq0_arlen = 0;
    #1 check_eq("single_grant", rq0_arready, 1);
    step();
    rq0_arvalid = 0; m_arready = 1;
    step();
    m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rid = 0; rq0_rready = 1;
    m_rdata[63:0] = 64'hDEAD_BEEF_0123_4567;
    step();
    m_rvalid = 0; m_rlast = 0;
    step();

    // Both requesting every cycle with no R traffic: alternation, then full at OUTSTD.
    rq0_arvalid = 1; rq1_arvalid = 1; m_arready = 1;
    for (int i = 0; i < 12; i++) step();
    rq0_arvalid = 0; rq1_arvalid = 0;
    m_rvalid = 1; m_rlast = 1; m_rid = ID_W'(owners[0]); rq0_rready = 1; rq1_rready = 1;
    step();
    m_rvalid = 0; rq0_arvalid = 1;
    for (int i = 0; i < 3; i++) step();
    rq0_arvalid = 0;
    for (int i = 0; i < 40 && (owners.size() != 0 || pend); i++) begin
      m_rvalid = 1; m_rlast = 1;
      m_rid = (owners.size() != 0) ? ID_W'(owners[0]) : '0;
      m_rvalid = owners.size() != 0;
      step();
    end
    m_rvalid = 0; m_rlast = 0;

    // Four-beat burst to requester 1 with its rready toggling.
    rq1_arvalid = 1; rq1_araddr = 64'h2000_0000; rq1_arlen = 3;
    step();
    rq1_arvalid = 0;
    step();
    begin
      int beat = 0;
      bit rr = 1;
      for (int i = 0; i < 16 && beat < 4; i++) begin
        m_rvalid = 1; m_rid = 1; m_rlast = (beat == 3); rq1_rready = rr;
        m_rdata[63:0] = 64'(beat + 100);
        step();
        if (rr) beat++;
        rr = !rr;
      end
    end
    m_rvalid = 0; m_rlast = 0;
    step();

    // Stray beat with nothing outstanding, then an ID mismatch on an owner-0 burst.
    m_rvalid = 1; m_rlast = 1; m_rid = 0;
    step();
    m_rvalid = 0; rq0_arvalid = 1; rq0_rready = 1;
    step();
    rq0_arvalid = 0;
    step();
    m_rvalid = 1; m_rlast = 1; m_rid = 1;
    step();
    m_rvalid = 0;
    step();

    // Reset while an AR is issuing with two bursts outstanding.
    mid_reset();
    rq0_arvalid = 1; rq1_arvalid = 1; m_arready = 1;
    for (int i = 0; i < 4; i++) step();
    rq1_arvalid = 0; m_arready = 0;
    step();
    check_eq("pre_rst_issue", m_arvalid, 1);
    mid_reset();
    rq0_arvalid = 1; rq1_arvalid = 1;
    #1 check_eq("post_rst_tie", rq0_arready, 1);
    step();

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) mid_reset();
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
